reg_file_multiport: RTL and testbench

//  Parametrised register file, successor to the 3-register data/result bank.
//  - DEPTH general registers, DATA_W bits each.
//  - Two write ports: a load port and an ALU result port.
//  - Two registered read ports with same-cycle write bypass.
//  - Per-register pending scoreboard: the controller marks a register pending when it

---
 rtl/reg_file_multiport.sv | 144 ++++++++++++++
 tb/tb_reg_file_multiport.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_multiport.sv
// Purpose    : DEPTH x DATA_W register file with load/result write ports, two
//              bypassed read ports and a per-register pending scoreboard.
// Latency    : reads are registered, data and rd_valid appear one edge after rd_en.
// Backpressure: none; pending operands are reported on rd_valid, and the
//              controller holds the ALU op until a read comes back valid.
//
// Ports
//   reg_clk, reg_rst_n          clock, async active-low reset
//   wr_en/wr_addr/wr_data       load-port write
//   res_en/res_addr/res_data    ALU result write, also clears pending
//   iss_en/iss_addr             marks a register as awaiting an ALU result
//   rd_en/rd_addr1/rd_addr2     read strobe and addresses for both ports
//   rd_data1/rd_data2/rd_valid  registered read results
//   pend_any                    OR of all pending bits
module reg_file_multiport #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  localparam int ADDR_W  = $clog2(DEPTH)
) (
  input  logic              reg_clk,
  input  logic              reg_rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  output logic              pend_any
);

  logic [DATA_W-1:0] r_regs    [DEPTH];
  logic [DEPTH-1:0]  r_pend;
  logic [DATA_W-1:0] r_rd_data1;
  logic [DATA_W-1:0] r_rd_data2;
  logic              r_rd_valid;

  logic [DATA_W-1:0] w_reg_nxt [DEPTH];
  logic [DEPTH-1:0]  w_pend_nxt;
  logic [DEPTH-1:0]  w_wr_hit;
  logic [DEPTH-1:0]  w_res_hit;
  logic [DEPTH-1:0]  w_iss_hit;
  logic [DATA_W-1:0] w_rd_val1;
  logic [DATA_W-1:0] w_rd_val2;
  logic              w_effpend1;
  logic              w_effpend2;

  // Register 0 is hardwired when ZERO_REG is set; out-of-range addresses never
  // match any index in the decode loops, so they drop writes and read as 0.
  function automatic logic writable(input int idx);
    return !((ZERO_REG != 0) && (idx == 0));
  endfunction

  // Per-register write/issue decode and next-state values.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_wr_hit[i]  = wr_en  && (wr_addr  == ADDR_W'(i)) && writable(i);
      w_res_hit[i] = res_en && (res_addr == ADDR_W'(i)) && writable(i);
      w_iss_hit[i] = iss_en && (iss_addr == ADDR_W'(i)) && writable(i);

      // Result port wins a same-address collision with the load port.
      if (w_res_hit[i]) begin
        w_reg_nxt[i] = res_data;
      end else if (w_wr_hit[i]) begin
        w_reg_nxt[i] = wr_data;
      end else begin
        w_reg_nxt[i] = r_regs[i];
      end

      // A new issue outranks a completing result on the same register: the
      // register now waits on the newer producer.
      if (w_iss_hit[i]) begin
        w_pend_nxt[i] = 1'b1;
      end else if (w_res_hit[i]) begin
        w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_pend[i];
      end
    end
  end

  // Read lookup. The next-state value already carries the same-cycle write
  // bypass, and a result landing this cycle satisfies a pending operand.
  always_comb begin
    w_rd_val1  = '0;
    w_rd_val2  = '0;
    w_effpend1 = 1'b0;
    w_effpend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr1 == ADDR_W'(i) && writable(i)) begin
        w_rd_val1  = w_reg_nxt[i];
        w_effpend1 = r_pend[i] && !w_res_hit[i];
      end
      if (rd_addr2 == ADDR_W'(i) && writable(i)) begin
        w_rd_val2  = w_reg_nxt[i];
        w_effpend2 = r_pend[i] && !w_res_hit[i];
      end
    end
  end

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= w_reg_nxt[i];
      end
      r_pend <= w_pend_nxt;
    end
  end

  // Read data updates on every rd_en even when an operand is still pending;
  // rd_valid tells the controller whether the pair can be consumed.
  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (rd_en) begin
        r_rd_data1 <= w_rd_val1;
        r_rd_data2 <= w_rd_val2;
      end
      r_rd_valid <= rd_en && !w_effpend1 && !w_effpend2;
    end
  end

  assign rd_data1 = r_rd_data1;
  assign rd_data2 = r_rd_data2;
  assign rd_valid = r_rd_valid;
  assign pend_any = |r_pend;

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: instance 0 uses the defaults (DEPTH=4,
// ZERO_REG=0), instance 1 uses DEPTH=6, ZERO_REG=1 so the hardwired register
// and out-of-range addresses can be exercised. Both share one stimulus bus.
module tb_reg_file_multiport;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en, res_en, iss_en, rd_en;
  logic [2:0] wr_addr, res_addr, iss_addr, rd_addr1, rd_addr2;
  logic [7:0] wr_data, res_data;

  logic [7:0] q_d1 [2];
  logic [7:0] q_d2 [2];
  logic       q_v  [2];
  logic       q_p  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_multiport #(.DATA_W(8), .DEPTH(4), .ZERO_REG(0)) dut0 (
    .reg_clk(clk), .reg_rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr[1:0]), .res_data(res_data),
    .iss_en(iss_en), .iss_addr(iss_addr[1:0]),
    .rd_en(rd_en), .rd_addr1(rd_addr1[1:0]), .rd_addr2(rd_addr2[1:0]),
    .rd_data1(q_d1[0]), .rd_data2(q_d2[0]), .rd_valid(q_v[0]), .pend_any(q_p[0])
  );

  reg_file_multiport #(.DATA_W(8), .DEPTH(6), .ZERO_REG(1)) dut1 (
    .reg_clk(clk), .reg_rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .res_en(res_en), .res_addr(res_addr), .res_data(res_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(q_d1[1]), .rd_data2(q_d2[1]), .rd_valid(q_v[1]), .pend_any(q_p[1])
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_reg  [2][8];
  bit   [7:0] m_pend [2];
  logic [7:0] m_d1   [2];
  logic [7:0] m_d2   [2];
  bit         m_v    [2];

  function automatic int eff(input int k, input logic [2:0] a);
    return (k == 0) ? int'(a[1:0]) : int'(a);
  endfunction

  function automatic bit ok(input int k, input int a);
    return (a < ((k == 0) ? 4 : 6)) && !(k == 1 && a == 0);
  endfunction

  function automatic logic [7:0] rd_val(input int k, input int a);
    if (!ok(k, a)) return 8'h00;
    if (res_en && eff(k, res_addr) == a) return res_data;
    if (wr_en && eff(k, wr_addr) == a) return wr_data;
    return m_reg[k][a];
  endfunction

  function automatic bit effpend(input int k, input int a);
    if (!ok(k, a)) return 1'b0;
    return m_pend[k][a] && !(res_en && eff(k, res_addr) == a);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 8; r++) m_reg[k][r] = 8'h00;
      m_pend[k] = '0;
      m_d1[k] = 8'h00;
      m_d2[k] = 8'h00;
      m_v[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int wa, ra, ia, a1, a2;
      wa = eff(k, wr_addr);
      ra = eff(k, res_addr);
      ia = eff(k, iss_addr);
      a1 = eff(k, rd_addr1);
      a2 = eff(k, rd_addr2);
      if (rd_en) begin
        m_d1[k] = rd_val(k, a1);
        m_d2[k] = rd_val(k, a2);
        m_v[k]  = !effpend(k, a1) && !effpend(k, a2);
      end else begin
        m_v[k] = 1'b0;
      end
      if (wr_en && ok(k, wa)) m_reg[k][wa] = wr_data;
      if (res_en && ok(k, ra)) begin
        m_reg[k][ra] = res_data;
        m_pend[k][ra] = 1'b0;
      end
      if (iss_en && ok(k, ia)) m_pend[k][ia] = 1'b1;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_clear();
      else        model_step();
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model i%0d rd_data1", k), q_d1[k], m_d1[k]);
        check($sformatf("model i%0d rd_data2", k), q_d2[k], m_d2[k]);
        check($sformatf("model i%0d rd_valid", k), {7'b0, q_v[k]}, {7'b0, m_v[k]});
        check($sformatf("model i%0d pend_any", k), {7'b0, q_p[k]}, {7'b0, |m_pend[k]});
      end
    end
  end

  // Literal expectation for one instance: d1, d2, rd_valid, pend_any.
  task automatic expect_lit(input string nm, input int k, input logic [7:0] d1,
                            input logic [7:0] d2, input logic v, input logic p);
    check($sformatf("%s i%0d d1", nm, k), q_d1[k], d1);
    check($sformatf("%s i%0d d2", nm, k), q_d2[k], d2);
    check($sformatf("%s i%0d valid", nm, k), {7'b0, q_v[k]}, {7'b0, v});
    check($sformatf("%s i%0d pend", nm, k), {7'b0, q_p[k]}, {7'b0, p});
  endtask

  // ---------------- stimulus ----------------
  task automatic idle();
    wr_en = 0; res_en = 0; iss_en = 0; rd_en = 0;
    wr_addr = 0; res_addr = 0; iss_addr = 0; rd_addr1 = 0; rd_addr2 = 0;
    wr_data = 0; res_data = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic res(input logic [2:0] a, input logic [7:0] d);
    res_en = 1; res_addr = a; res_data = d;
  endtask

  task automatic iss(input logic [2:0] a);
    iss_en = 1; iss_addr = a;
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
    rd_en = 1; rd_addr1 = a1; rd_addr2 = a2;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1. reads straight after reset
    rd(0, 1); cyc();
    expect_lit("reset_read", 0, 8'h00, 8'h00, 1, 0);
    expect_lit("reset_read", 1, 8'h00, 8'h00, 1, 0);

    // 2. plain write then read; same-cycle write bypass
    wr(1, 8'hA5); cyc();
    rd(1, 2); wr(2, 8'h3C); cyc();
    expect_lit("bypass_wr", 0, 8'hA5, 8'h3C, 1, 0);
    expect_lit("bypass_wr", 1, 8'hA5, 8'h3C, 1, 0);

    // 3. both write ports on one address: result wins, also on bypass
    wr(3, 8'h11); res(3, 8'h22); rd(3, 1); cyc();
    expect_lit("double_wr", 0, 8'h22, 8'hA5, 1, 0);
    rd(1, 3); cyc();
    expect_lit("double_wr_hold", 1, 8'hA5, 8'h22, 1, 0);

    // 4. pending operand, then result arriving in the read cycle
    iss(2); cyc();
    check("iss_pend i0", {7'b0, q_p[0]}, 8'h01);
    rd(2, 2); cyc();
    expect_lit("pending_read", 0, 8'h3C, 8'h3C, 0, 1);
    res(2, 8'h7F); rd(2, 0); cyc();
    expect_lit("res_satisfies", 0, 8'h7F, 8'h00, 1, 0);
    expect_lit("res_satisfies", 1, 8'h7F, 8'h00, 1, 0);

    // 5. issue and result on one address: set wins
    iss(1); res(1, 8'h44); cyc();
    check("set_wins i0", {7'b0, q_p[0]}, 8'h01);
    rd(1, 3); cyc();
    expect_lit("set_wins_rd", 1, 8'h44, 8'h22, 0, 1);
    res(1, 8'h45); cyc();
    check("clear i1", {7'b0, q_p[1]}, 8'h00);

    // 5b. register 0: writable on instance 0, hardwired on instance 1
    wr(0, 8'hFF); cyc();
    rd(0, 0); cyc();
    expect_lit("zero_reg", 0, 8'hFF, 8'hFF, 1, 0);
    expect_lit("zero_reg", 1, 8'h00, 8'h00, 1, 0);
    iss(0); cyc();
    check("zero_iss i0", {7'b0, q_p[0]}, 8'h01);
    check("zero_iss i1", {7'b0, q_p[1]}, 8'h00);
    res(0, 8'h01); cyc();

    // out-of-range on instance 1 (aliases to regs 3/2 on instance 0)
    wr(7, 8'h99); rd(7, 6); iss(6); cyc();
    expect_lit("oob", 1, 8'h00, 8'h00, 1, 0);
    expect_lit("oob_alias", 0, 8'h99, 8'h7F, 1, 1);
    res(2, 8'h12); cyc();

    // rd_en low holds data and drops rd_valid
    rd(3, 3); cyc();
    rd_addr1 = 1; cyc();
    expect_lit("hold", 0, 8'h99, 8'h99, 0, 0);
    expect_lit("hold", 1, 8'h22, 8'h22, 0, 0);

    // 6. async reset between edges with pending bits and data set
    iss(3); wr(3, 8'h55); rd(3, 1); cyc();
    expect_lit("pre_reset", 0, 8'h55, 8'h45, 1, 1);
    expect_lit("pre_reset", 1, 8'h55, 8'h45, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    expect_lit("async_reset", 0, 8'h00, 8'h00, 0, 0);
    expect_lit("async_reset", 1, 8'h00, 8'h00, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    rd(3, 1); cyc();
    expect_lit("post_reset", 0, 8'h00, 8'h00, 1, 0);
    expect_lit("post_reset", 1, 8'h00, 8'h00, 1, 0);

    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
